pipe_stage_reg: RTL and testbench

//   Parametrised inter-stage pipeline register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg_pkg.sv | 16 +
 rtl/pipe_stage_reg_sat_counter.sv | 31 +++
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the core's inter-stage pipeline registers.
// Payload widths size DATA_W at each stage boundary.
package pipe_stage_reg_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam int IF_ID_W  = 64;   // {pc, inst}
   localparam int ID_EX_W  = 160;
   localparam int EX_MEM_W = 128;
   localparam int MEM_WB_W = 96;

   function automatic logic [1:0] entry_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for the stage performance counters; it sticks at all-ones.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// flush/hold/bubble controls and saturating stall/flush counters.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_INST),
   parameter bit                SKID      = 1'b1,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic              hold,
   input  logic              kill_in,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic              alive_q;
   logic              acc;
   logic              rel;
   logic              stall_inc;
   logic              flush_inc;

   always_comb begin
      acc = in_valid & in_ready & ~kill_in & ~flush;
      rel = main_valid_q & out_ready & ~hold & ~flush;
   end

   generate
      if (SKID) begin : g_skid
         // alive_q keeps in_ready low while rst is asserted
         assign in_ready = alive_q & ~skid_valid_q & ~hold;

         always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush) begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end else if (!hold) begin
               if (rel) begin
                  if (skid_valid_q) begin
                     main_data_d  = skid_data_q;
                     skid_valid_d = acc;
                     if (acc) begin
                        skid_data_d = in_data;
                     end
                  end else begin
                     main_valid_d = acc;
                     if (acc) begin
                        main_data_d = in_data;
                     end
                  end
               end else if (acc) begin
                  if (main_valid_q) begin
                     skid_valid_d = 1'b1;
                     skid_data_d  = in_data;
                  end else begin
                     main_valid_d = 1'b1;
                     main_data_d  = in_data;
                  end
               end
            end
         end
      end else begin : g_single
         assign in_ready = alive_q & ~hold & (~main_valid_q | out_ready);

         always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            if (flush) begin
               main_valid_d = 1'b0;
            end else if (acc) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
            end else if (rel) begin
               main_valid_d = 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         alive_q      <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         alive_q      <= 1'b1;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_valid_q ? main_data_q : NOP_VALUE;
   assign occupancy = entry_count(main_valid_q, skid_valid_q);

   assign stall_inc = main_valid_q & (hold | ~out_ready);
   assign flush_inc = flush & (main_valid_q | skid_valid_q);

   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance and a SKID=0 instance share stimulus.
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int          DW  = 64;
   localparam int          CW  = 4;
   localparam logic [63:0] NOP = 64'h13;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, out_ready, flush, hold, kill_in;
   logic [DW-1:0] in_data;

   logic          in_ready,  out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   logic          in_ready0, out_valid0;
   logic [DW-1:0] out_data0;
   logic [1:0]    occupancy0;
   logic [CW-1:0] stall_cnt0, flush_cnt0;

   int errors = 0;
   int checks = 0;

   logic [63:0] vec [5];

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
      .hold(hold), .kill_in(kill_in), .occupancy(occupancy), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .CNT_W(CW)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .flush(flush),
      .hold(hold), .kill_in(kill_in), .occupancy(occupancy0), .stall_cnt(stall_cnt0),
      .flush_cnt(flush_cnt0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
      kill_in = 1'b0; in_data = '0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; hold = 1'b0;
      kill_in = 1'b0; in_data = '0;
      tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== NOP) begin errors++; $display("FAIL rst_out_data got=%h exp=%h", out_data, NOP); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
      checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
      rst = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready0 got=%b exp=1", in_ready0); end
   endtask

   task automatic test_stream();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = vec[i];
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== vec[i]) begin errors++; $display("FAIL stream_data%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vec[i]); end
         checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ%0d got=%0d exp=1", i, occupancy); end
         checks++; if (out_data0 !== vec[i]) begin errors++; $display("FAIL stream_data0_%0d got=%h exp=%h", i, out_data0, vec[i]); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin errors++; $display("FAIL stream_drain got=%b/%h exp=0/%h", out_valid, out_data, NOP); end
      checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
   endtask

   task automatic test_skid();
      do_reset();
      in_valid = 1'b1; in_data = vec[0]; out_ready = 1'b0;
      tick();
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_load got=occ%0d/rdy%b exp=occ1/rdy1", occupancy, in_ready); end
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL skid0_blocked got=%b exp=0", in_ready0); end
      in_data = vec[1];
      tick();
      checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_fill got=occ%0d/rdy%b exp=occ2/rdy0", occupancy, in_ready); end
      in_data = vec[2];
      tick();
      checks++; if (occupancy !== 2'd2 || out_data !== vec[0]) begin errors++; $display("FAIL skid_hold_up got=occ%0d/%h exp=occ2/%h", occupancy, out_data, vec[0]); end
      checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL skid_stall got=%0d exp=2", stall_cnt); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL skid0_ready_comb got=%b exp=1", in_ready0); end
      tick();
      checks++; if (out_data !== vec[1] || occupancy !== 2'd1) begin errors++; $display("FAIL skid_drain_b got=%h/occ%0d exp=%h/occ1", out_data, occupancy, vec[1]); end
      tick();
      checks++; if (out_data !== vec[2] || out_valid !== 1'b1) begin errors++; $display("FAIL skid_drain_c got=%h/%b exp=%h/1", out_data, out_valid, vec[2]); end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      in_valid = 1'b1; in_data = vec[0]; out_ready = 1'b0;
      tick();
      in_data = vec[1];
      tick();
      flush = 1'b1; in_data = vec[2];
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin errors++; $display("FAIL flush_state got=%b/%h/occ%0d exp=0/%h/occ0", out_valid, out_data, occupancy, NOP); end
      checks++; if (flush_cnt !== 4'd1 || flush_cnt0 !== 4'd1) begin errors++; $display("FAIL flush_cnt got=%0d/%0d exp=1/1", flush_cnt, flush_cnt0); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      in_valid = 1'b0;
      tick();
      flush = 1'b0; out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || flush_cnt !== 4'd1) begin errors++; $display("FAIL flush_empty got=%b/cnt%0d exp=0/cnt1", out_valid, flush_cnt); end
   endtask

   task automatic test_hold();
      do_reset();
      in_valid = 1'b1; in_data = vec[3]; out_ready = 1'b1;
      tick();
      hold = 1'b1; in_data = vec[4];
      #1;
      checks++; if (in_ready !== 1'b0 || in_ready0 !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%b/%b exp=0/0", in_ready, in_ready0); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== vec[3]) begin errors++; $display("FAIL hold_stable%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vec[3]); end
      end
      checks++; if (stall_cnt !== 4'd3 || stall_cnt0 !== 4'd3) begin errors++; $display("FAIL hold_stall got=%0d/%0d exp=3/3", stall_cnt, stall_cnt0); end
      hold = 1'b0; in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin errors++; $display("FAIL hold_release got=%b/%b exp=0/0", out_valid, out_valid0); end
      checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL hold_stall_after got=%0d exp=3", stall_cnt); end
   endtask

   task automatic test_kill();
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; kill_in = 1'b1; in_data = 64'hDEAD_BEEF_0000_0BAD;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kill_in_ready got=%b exp=1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin errors++; $display("FAIL kill_bubble got=%b/%h/occ%0d exp=0/%h/occ0", out_valid, out_data, occupancy, NOP); end
      kill_in = 1'b0; in_data = vec[2];
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== vec[2]) begin errors++; $display("FAIL kill_next got=%b/%h exp=1/%h", out_valid, out_data, vec[2]); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_saturate_and_async_reset();
      do_reset();
      in_valid = 1'b1; in_data = vec[1]; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14 got=%0d exp=14", stall_cnt); end
         end
         if (i == 15) begin
            checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15 got=%0d exp=15", stall_cnt); end
         end
      end
      checks++; if (stall_cnt !== 4'd15 || stall_cnt0 !== 4'd15) begin errors++; $display("FAIL sat_20 got=%0d/%0d exp=15/15", stall_cnt, stall_cnt0); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== NOP || occupancy !== 2'd0) begin errors++; $display("FAIL async_rst_out got=%b/%h/occ%0d exp=0/%h/occ0", out_valid, out_data, occupancy, NOP); end
      checks++; if (stall_cnt !== '0 || in_ready !== 1'b0) begin errors++; $display("FAIL async_rst_cnt got=%0d/rdy%b exp=0/rdy0", stall_cnt, in_ready); end
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      vec[0] = 64'h0000_1000_0000_0A01;
      vec[1] = 64'h0000_1004_0000_0B02;
      vec[2] = 64'h0000_1008_0000_0C03;
      vec[3] = 64'h0000_100C_0000_0D04;
      vec[4] = 64'h0000_1010_0000_0E05;
      test_reset();
      test_stream();
      test_skid();
      test_flush();
      test_hold();
      test_kill();
      test_saturate_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
